// File: rtl/nn_pkg.sv
// Shared constants, lane codes and FSM state type for the RNN core stream driver.
// Word contents are opaque IEEE-754 singles; the FP constants are for reference.
package nn_pkg;
  localparam int DATA_W  = 32;
  localparam int N_WORDS = 9;
  localparam int IDX_W   = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  localparam logic [1:0] LANE_U = 2'd0;
  localparam logic [1:0] LANE_W = 2'd1;
  localparam logic [1:0] LANE_V = 2'd2;
  localparam logic [1:0] LANE_X = 2'd3;

  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [DATA_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    COLLECT = 2'd2
  } state_t;
endpackage

// File: rtl/nn_word_bank.sv
// N_WORDS x DATA_W register file with one write port and one combinational read port.
// Accesses to indices above the last word are ignored on write and read back as zero.
module nn_word_bank
  import nn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N_WORDS];

  // Word storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) begin
        mem[i] <= FP_ZERO;
      end
    end else if (we && (waddr <= LAST_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST_IDX) ? mem[raddr] : FP_ZERO;
endmodule

// File: rtl/nn_stream_driver.sv
// Host-side master for the RNN core: streams the loaded U/W/V/X frame on the four
// lanes for N_WORDS cycles, then collects N_WORDS result words with an idle timeout.
module nn_stream_driver
  import nn_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_spur,
  output logic              in_valid_u,
  output logic              in_valid_w,
  output logic              in_valid_v,
  output logic              in_valid_x,
  output logic [DATA_W-1:0] weight_u,
  output logic [DATA_W-1:0] weight_w,
  output logic [DATA_W-1:0] weight_v,
  output logic [DATA_W-1:0] data_x,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [IDX_W-1:0]  cnt, cnt_nx;
  logic [IDLE_W-1:0] idle, idle_nx, idle_inc;
  logic              lane_valid, valid_nx, load_nx;
  logic              busy_nx, done_nx, err_timeout_nx, err_spur_nx;
  logic              res_we, bank_we;
  logic [DATA_W-1:0] u_rd, w_rd, v_rd, x_rd;

  // Banks are writable only while idle, so a running frame can never be corrupted.
  assign bank_we = wr_en && (state == IDLE);

  nn_word_bank u_bank_u (.clk(clk), .rst_n(rst_n), .we(bank_we && (wr_sel == LANE_U)),
                         .waddr(wr_addr), .wdata(wr_data), .raddr(idx), .rdata(u_rd));
  nn_word_bank u_bank_w (.clk(clk), .rst_n(rst_n), .we(bank_we && (wr_sel == LANE_W)),
                         .waddr(wr_addr), .wdata(wr_data), .raddr(idx), .rdata(w_rd));
  nn_word_bank u_bank_v (.clk(clk), .rst_n(rst_n), .we(bank_we && (wr_sel == LANE_V)),
                         .waddr(wr_addr), .wdata(wr_data), .raddr(idx), .rdata(v_rd));
  nn_word_bank u_bank_x (.clk(clk), .rst_n(rst_n), .we(bank_we && (wr_sel == LANE_X)),
                         .waddr(wr_addr), .wdata(wr_data), .raddr(idx), .rdata(x_rd));
  nn_word_bank u_bank_res (.clk(clk), .rst_n(rst_n), .we(res_we),
                           .waddr(cnt), .wdata(out), .raddr(rd_addr), .rdata(rd_data));

  assign in_valid_u = lane_valid;
  assign in_valid_w = lane_valid;
  assign in_valid_v = lane_valid;
  assign in_valid_x = lane_valid;

  // Next-state and next-output logic; idx stays 0 in IDLE so word 0 is presented on start.
  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    cnt_nx         = cnt;
    idle_nx        = idle;
    valid_nx       = 1'b0;
    load_nx        = 1'b0;
    busy_nx        = busy;
    done_nx        = 1'b0;
    err_timeout_nx = err_timeout;
    err_spur_nx    = err_spur;
    res_we         = 1'b0;
    idle_inc       = (idle == IDLE_MAX) ? idle : idle + IDLE_ONE;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx       = SEND;
          idx_nx         = 4'd1;
          valid_nx       = 1'b1;
          load_nx        = 1'b1;
          busy_nx        = 1'b1;
          err_timeout_nx = 1'b0;
          err_spur_nx    = out_valid;
        end else begin
          err_spur_nx = err_spur | out_valid;
        end
      end
      SEND: begin
        err_spur_nx = err_spur | out_valid;
        if (idx <= LAST_IDX) begin
          valid_nx = 1'b1;
          load_nx  = 1'b1;
          idx_nx   = idx + 4'd1;
        end else begin
          state_nx = COLLECT;
          idx_nx   = 4'd0;
          cnt_nx   = 4'd0;
          idle_nx  = IDLE_ZERO;
        end
      end
      COLLECT: begin
        if (out_valid) begin
          res_we  = 1'b1;
          idle_nx = IDLE_ZERO;
          if (cnt == LAST_IDX) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end else if (idle_inc == IDLE_MAX) begin
          state_nx       = IDLE;
          cnt_nx         = 4'd0;
          idle_nx        = IDLE_ZERO;
          busy_nx        = 1'b0;
          done_nx        = 1'b1;
          err_timeout_nx = 1'b1;
        end else begin
          idle_nx = idle_inc;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
        cnt_nx   = 4'd0;
        idle_nx  = IDLE_ZERO;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counters and registered outputs; lane words return to zero outside the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 4'd0;
      cnt         <= 4'd0;
      idle        <= IDLE_ZERO;
      lane_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_spur    <= 1'b0;
      weight_u    <= FP_ZERO;
      weight_w    <= FP_ZERO;
      weight_v    <= FP_ZERO;
      data_x      <= FP_ZERO;
    end else begin
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      idle        <= idle_nx;
      lane_valid  <= valid_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      err_timeout <= err_timeout_nx;
      err_spur    <= err_spur_nx;
      weight_u    <= load_nx ? u_rd : FP_ZERO;
      weight_w    <= load_nx ? w_rd : FP_ZERO;
      weight_v    <= load_nx ? v_rd : FP_ZERO;
      data_x      <= load_nx ? x_rd : FP_ZERO;
    end
  end
endmodule

// File: tb/tb_nn_stream_driver.sv
// Scoreboard bench for nn_stream_driver: a frame-level model predicts the lane stream,
// done/error flags and result bank; monitors compare whenever the DUT presents output.
module tb_nn_stream_driver;
  import nn_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        start = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] rd_data;
  logic        busy, done, err_timeout, err_spur;
  logic        in_valid_u, in_valid_w, in_valid_v, in_valid_x;
  logic [31:0] weight_u, weight_w, weight_v, data_x;
  logic        out_valid = 1'b0;
  logic [31:0] out = 32'd0;

  nn_stream_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_spur(err_spur),
    .in_valid_u(in_valid_u), .in_valid_w(in_valid_w), .in_valid_v(in_valid_v),
    .in_valid_x(in_valid_x), .weight_u(weight_u), .weight_w(weight_w),
    .weight_v(weight_v), .data_x(data_x), .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] u, w, v, x;} lane_t;
  typedef struct packed {logic tmo; logic spur;} done_t;

  lane_t       stream_q[$];
  done_t       done_q[$];
  logic [31:0] mb[4][9];
  logic [31:0] mres[9];
  int          n_pass = 0;
  int          n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane monitor: each valid cycle must carry the next expected word on all four lanes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid_u || in_valid_w || in_valid_v || in_valid_x) begin
        if (stream_q.size() == 0) begin
          check("stream_extra", {31'd0, in_valid_u}, 32'd0);
        end else begin
          lane_t e;
          e = stream_q.pop_front();
          check("valid_all", {28'd0, in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 32'hF);
          check("lane_u", weight_u, e.u);
          check("lane_w", weight_w, e.w);
          check("lane_v", weight_v, e.v);
          check("lane_x", data_x, e.x);
        end
      end else begin
        check("stream_gap", stream_q.size(), 32'd0);
        check("lane_idle", weight_u | weight_w | weight_v | data_x, 32'd0);
      end
    end
  end

  // Done monitor: every done pulse must match one predicted frame end.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_q.size() == 0) begin
        check("done_extra", {31'd0, done}, 32'd0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("err_timeout_at_done", {31'd0, err_timeout}, {31'd0, d.tmo});
        check("err_spur_at_done", {31'd0, err_spur}, {31'd0, d.spur});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic write_word(input int lane, input int addr, input logic [31:0] val);
    wr_en = 1'b1; wr_sel = 2'(lane); wr_addr = 4'(addr); wr_data = val;
    tick();
    wr_en = 1'b0;
    if (addr < 9) mb[lane][addr] = val;
  endtask

  task automatic load_banks(input bit rnd);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 9; i++) write_word(l, i, rnd ? $urandom : 32'(((l + 1) << 8) + i));
      if (rnd) write_word(l, $urandom_range(9, 15), $urandom);
    end
  endtask

  task automatic run_frame(input int n_ret, input int gap, input bit rnd_data,
                           input logic [31:0] base, input bit poke, input bit spur_after);
    int cyc;
    logic [31:0] d;
    done_q.push_back('{tmo: (n_ret < 9), spur: 1'b0});
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) stream_q.push_back('{mb[0][i], mb[1][i], mb[2][i], mb[3][i]});
    #1 start = 1'b0;
    @(negedge clk);
    check("err_clear", {30'd0, err_timeout, err_spur}, 32'd0);
    check("busy_start", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (stream_q.size() != 0 && cyc < 30) begin
      start = poke && ($urandom_range(0, 2) == 0);
      wr_en = poke && ($urandom_range(0, 1) == 0);
      wr_sel = 2'($urandom_range(0, 3)); wr_addr = 4'($urandom_range(0, 8)); wr_data = $urandom;
      tick();
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0;
    check("burst_drained", stream_q.size(), 32'd0);
    repeat (3) tick();
    check("busy_collect", {31'd0, busy}, 32'd1);
    for (int j = 0; j < n_ret; j++) begin
      d = rnd_data ? $urandom : base + 32'(j);
      out_valid = 1'b1; out = d; mres[j] = d;
      start = poke && ($urandom_range(0, 2) == 0);
      wr_en = poke && ($urandom_range(0, 1) == 0);
      wr_sel = 2'($urandom_range(0, 3)); wr_addr = 4'($urandom_range(0, 8)); wr_data = $urandom;
      tick();
      out_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (j < n_ret - 1) repeat (gap) tick();
    end
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (done) break;
      cyc++;
    end
    check("done_latency", cyc, (n_ret < 9) ? TO : 0);
    if (spur_after) begin
      @(posedge clk); #1 out_valid = 1'b1;
      @(negedge clk); check("done_pulse", {31'd0, done}, 32'd0);
      @(posedge clk); #1 out_valid = 1'b0;
      @(negedge clk); check("spur_after_done", {31'd0, err_spur}, 32'd1);
    end else begin
      @(negedge clk); check("done_pulse", {31'd0, done}, 32'd0);
    end
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      #1 check($sformatf("res_%0d", a), rd_data, (a < 9) ? mres[a] : 32'd0);
    end
    check("err_timeout_sticky", {31'd0, err_timeout}, {31'd0, (n_ret < 9)});
    check("busy_end", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic reset_mid_frame();
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) stream_q.push_back('{mb[0][i], mb[1][i], mb[2][i], mb[3][i]});
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {28'd0, in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 32'd0);
    check("rst_lanes", weight_u | weight_w | weight_v | data_x, 32'd0);
    check("rst_flags", {28'd0, busy, done, err_timeout, err_spur}, 32'd0);
    stream_q.delete();
    for (int l = 0; l < 4; l++) for (int i = 0; i < 9; i++) mb[l][i] = 32'd0;
    for (int i = 0; i < 9; i++) mres[i] = 32'd0;
    rd_addr = 4'd3;
    #1 check("rst_rd_data", rd_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n_ret;
    for (int l = 0; l < 4; l++) for (int i = 0; i < 9; i++) mb[l][i] = 32'd0;
    for (int i = 0; i < 9; i++) mres[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {28'd0, busy, done, err_timeout, err_spur}, 32'd0);
    check("reset_valid", {28'd0, in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 32'd0);
    check("reset_lanes", weight_u | weight_w | weight_v | data_x, 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    load_banks(1'b0);
    run_frame(9, 0, 1'b0, 32'h0000_00A0, 1'b0, 1'b0);
    run_frame(4, 1, 1'b1, 32'd0, 1'b0, 1'b0);
    load_banks(1'b1);
    run_frame(9, 1, 1'b1, 32'd0, 1'b1, 1'b1);

    tick();
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    @(negedge clk);
    check("spur_idle", {31'd0, err_spur}, 32'd1);
    check("spur_no_done", {31'd0, done}, 32'd0);
    tick();
    run_frame(9, 0, 1'b1, 32'd0, 1'b0, 1'b0);

    reset_mid_frame();
    load_banks(1'b1);
    run_frame(9, 0, 1'b1, 32'd0, 1'b0, 1'b0);
    run_frame(9, 2, 1'b1, 32'd0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      load_banks(1'b1);
      n_ret = ($urandom_range(0, 1) == 0) ? 9 : $urandom_range(1, 8);
      run_frame(n_ret, $urandom_range(0, 3), 1'b1, 32'd0, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) tick();
    check("stream_q_empty", stream_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
